// File: rtl/integer_mul_add_rebuild_if.sv
// Handshake/operand bundle for integer_mul_add_rebuild.
// MULADD_REM_CHECK_EN adds the rem_err result flag.
interface integer_mul_add_rebuild_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] a;
    logic             ovf;
`ifdef MULADD_REM_CHECK_EN
    logic             rem_err;
`endif

    modport master (
        output start, q, d, r,
`ifdef MULADD_REM_CHECK_EN
        input  rem_err,
`endif
        input  busy, done, a, ovf
    );

    modport slave (
        input  start, q, d, r,
`ifdef MULADD_REM_CHECK_EN
        output rem_err,
`endif
        output busy, done, a, ovf
    );
endinterface

// File: rtl/integer_mul_add_rebuild.sv
// Iterative shift-add rebuild of a = q*d + r, one multiplier bit per clock.
// Optional MULADD_REM_CHECK_EN flags operand triples where r >= d.
module integer_mul_add_rebuild #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    integer_mul_add_rebuild_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   a_q;
    logic               ovf_q;
    logic [2*WIDTH-1:0] acc_sum;

`ifdef MULADD_REM_CHECK_EN
    logic rem_flag;
    logic rem_err_q;
`endif

    always_comb begin
        acc_sum = acc;
        if (mplier[0]) begin
            acc_sum = acc + mcand;
        end
    end

    // The final result is captured from acc_sum so the last partial product lands on the CALC->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            a_q       <= '0;
            ovf_q     <= 1'b0;
`ifdef MULADD_REM_CHECK_EN
            rem_flag  <= 1'b0;
            rem_err_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        a_q       <= acc_sum[WIDTH-1:0];
                        ovf_q     <= |acc_sum[2*WIDTH-1:WIDTH];
`ifdef MULADD_REM_CHECK_EN
                        rem_err_q <= rem_flag;
`endif
                    end
                end
                default: begin
                    if (bus.start) begin
                        state    <= CALC;
                        busy_q   <= 1'b1;
                        acc      <= {{WIDTH{1'b0}}, bus.r};
                        mcand    <= {{WIDTH{1'b0}}, bus.d};
                        mplier   <= bus.q;
                        cnt      <= '0;
`ifdef MULADD_REM_CHECK_EN
                        rem_flag <= (bus.r >= bus.d);
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.a    = a_q;
    assign bus.ovf  = ovf_q;
`ifdef MULADD_REM_CHECK_EN
    assign bus.rem_err = rem_err_q;
`endif

endmodule

// File: tb/tb_integer_mul_add_rebuild.sv
// Directed self-checking bench for integer_mul_add_rebuild (WIDTH=32).
// Rem-check vectors run only when MULADD_REM_CHECK_EN is defined.
module tb_integer_mul_add_rebuild;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    integer_mul_add_rebuild_if #(.WIDTH(WIDTH)) bus ();

    integer_mul_add_rebuild #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] qv, input logic [31:0] dv, input logic [31:0] rv);
        @(negedge clk);
        bus.q = qv;
        bus.d = dv;
        bus.r = rv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done; busy_cycles tallies busy-high cycles on the way.
    task automatic waitDone(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (!bus.done && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (bus.busy) busy_cycles++;
        end
    endtask

    initial begin
        int cyc;
        int bcyc;
        checks   = 0;
        failures = 0;
        bus.start = 1'b0;
        bus.q = '0;
        bus.d = '0;
        bus.r = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_a", 64'(bus.a), 64'd0);
        checkOutput("reset_ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(32'd1234, 32'd1000, 32'd101);
        waitDone(cyc, bcyc);
        checkOutput("basic_latency", 64'(cyc), 64'd33);
        checkOutput("basic_busy_cycles", 64'(bcyc), 64'd32);
        checkOutput("basic_busy_in_done", 64'(bus.busy), 64'd0);
        checkOutput("basic_a", 64'(bus.a), 64'd1234101);
        checkOutput("basic_ovf", 64'(bus.ovf), 64'd0);
`ifdef MULADD_REM_CHECK_EN
        checkOutput("basic_rem_err", 64'(bus.rem_err), 64'd0);
`endif

        bus.q = 32'd2468;
        bus.d = 32'd1000;
        bus.r = 32'd202;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("b2b_restart_busy", 64'(bus.busy), 64'd1);
        checkOutput("b2b_done_one_cycle", 64'(bus.done), 64'd0);
        checkOutput("b2b_a_held", 64'(bus.a), 64'd1234101);
        waitDone(cyc, bcyc);
        checkOutput("b2b_latency", 64'(cyc), 64'd33);
        checkOutput("b2b_a", 64'(bus.a), 64'd2468202);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(cyc, bcyc);
        checkOutput("allones_a", 64'(bus.a), 64'd0);
        checkOutput("allones_ovf", 64'(bus.ovf), 64'd1);

        applyStimulus(32'h0001_0000, 32'h0001_0000, 32'd5);
        waitDone(cyc, bcyc);
        checkOutput("pow2_a", 64'(bus.a), 64'd5);
        checkOutput("pow2_ovf", 64'(bus.ovf), 64'd1);

        applyStimulus(32'd123, 32'd0, 32'd9);
        waitDone(cyc, bcyc);
        checkOutput("dzero_a", 64'(bus.a), 64'd9);
        checkOutput("dzero_ovf", 64'(bus.ovf), 64'd0);

        // Start pulse mid-CALC with different operands must be ignored.
        applyStimulus(32'd0, 32'd0, 32'd7);
        repeat (5) @(negedge clk);
        bus.q = 32'd55;
        bus.d = 32'd66;
        bus.r = 32'd77;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(cyc, bcyc);
        checkOutput("ignore_latency", 64'(cyc + 6), 64'd33);
        checkOutput("zero_a", 64'(bus.a), 64'd7);
        checkOutput("zero_ovf", 64'(bus.ovf), 64'd0);
`ifdef MULADD_REM_CHECK_EN
        checkOutput("zero_rem_err", 64'(bus.rem_err), 64'd1);
`endif

        applyStimulus(32'd3, 32'd7, 32'd2);
        waitDone(cyc, bcyc);
        checkOutput("small_a", 64'(bus.a), 64'd23);
        @(negedge clk);

        applyStimulus(32'd1234, 32'd1000, 32'd101);
        repeat (10) @(negedge clk);
        checkOutput("pre_reset_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        checkOutput("abort_a", 64'(bus.a), 64'd0);
        checkOutput("abort_ovf", 64'(bus.ovf), 64'd0);
        bcyc = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) bcyc++;
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) bcyc++;
        end
        checkOutput("abort_no_done", 64'(bcyc), 64'd0);
        applyStimulus(32'd2468, 32'd1000, 32'd202);
        waitDone(cyc, bcyc);
        checkOutput("after_reset_latency", 64'(cyc), 64'd33);
        checkOutput("after_reset_a", 64'(bus.a), 64'd2468202);

`ifdef MULADD_REM_CHECK_EN
        applyStimulus(32'd5, 32'd1000, 32'd1000);
        waitDone(cyc, bcyc);
        checkOutput("remchk_eq_a", 64'(bus.a), 64'd6000);
        checkOutput("remchk_eq_err", 64'(bus.rem_err), 64'd1);
        applyStimulus(32'd5, 32'd1000, 32'd999);
        waitDone(cyc, bcyc);
        checkOutput("remchk_lt_a", 64'(bus.a), 64'd5999);
        checkOutput("remchk_lt_err", 64'(bus.rem_err), 64'd0);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
